// File: rtl/seg_pkg.sv
// Shared constants, segment patterns and scan FSM state type for the
// eight-digit multiplexed seven-segment scan controller.
package seg_pkg;

    localparam int          NUM_DIGITS = 8;
    localparam logic [7:0]  ANODE_OFF  = 8'hFF;
    localparam logic [6:0]  SEG_OFF    = 7'h7F;

    // Active-low {g,f,e,d,c,b,a} patterns for hex digits 0..F
    localparam logic [6:0] HEX_SEG [16] = '{
        7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
        7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
    };

    typedef enum logic {
        ST_BLANK = 1'b0,
        ST_SHOW  = 1'b1
    } scan_state_t;

endpackage

// File: rtl/seg_hex_decode.sv
// Combinational hex nibble to active-low seven-segment pattern decoder.
module seg_hex_decode
    import seg_pkg::*;
(
    input  logic [3:0] nibble,
    output logic [6:0] seg
);

    assign seg = HEX_SEG[nibble];

endmodule

// File: rtl/seg_scan_ctrl.sv
// Eight-digit seven-segment scan controller with tear-free frame-boundary updates.
// Define SEG_GHOST_BLANK_EN to enable BLANK_CYC anti-ghosting dead-time per slot.
module seg_scan_ctrl
    import seg_pkg::*;
#(
    parameter int TICK_DIV  = 100000,
    parameter int BLANK_CYC = 1000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        upd_valid,
    output logic        upd_ready,
    input  logic [31:0] upd_digits,
    input  logic [7:0]  upd_en,
    input  logic [7:0]  upd_dp,
    output logic [7:0]  anode,
    output logic [6:0]  seg,
    output logic        dp,
    output logic        frame_start
);

    localparam int CNT_W = (TICK_DIV < 2) ? 1 : $clog2(TICK_DIV);

`ifdef SEG_GHOST_BLANK_EN
    localparam int BLANK_EFF = BLANK_CYC;
    generate
        if (BLANK_CYC >= TICK_DIV || TICK_DIV < 2) begin : g_bad_params
            $error("seg_scan_ctrl: need TICK_DIV >= 2 and BLANK_CYC < TICK_DIV");
        end
    endgenerate
`else
    // Dead-time disabled: BLANK_CYC stays on the interface but has no effect
    localparam int BLANK_EFF = 0 * BLANK_CYC;
    generate
        if (TICK_DIV < 2) begin : g_bad_params
            $error("seg_scan_ctrl: need TICK_DIV >= 2");
        end
    endgenerate
`endif

    logic [CNT_W-1:0] cnt_reg, cnt_next;
    logic [2:0]       idx_reg, idx_next;
    scan_state_t      state_reg, state_next;
    logic             slot_end, frame_end, show_now, handshake;

    logic [31:0] active_digits_reg, pend_digits_reg;
    logic [7:0]  active_en_reg, active_dp_reg, pend_en_reg, pend_dp_reg;
    logic        pend_valid_reg;

    logic [7:0]  anode_reg, anode_sel;
    logic [6:0]  seg_reg, seg_dec;
    logic        dp_reg, frame_start_reg;

    always_comb begin
        slot_end   = (cnt_reg == CNT_W'(TICK_DIV - 1));
        frame_end  = slot_end && (idx_reg == 3'd7);
        cnt_next   = slot_end ? '0 : cnt_reg + 1'b1;
        idx_next   = slot_end ? idx_reg + 3'd1 : idx_reg;
        state_next = state_reg;
        case (state_reg)
            ST_BLANK: if (BLANK_EFF == 0 || cnt_next == CNT_W'(BLANK_EFF)) state_next = ST_SHOW;
            ST_SHOW:  if (slot_end && BLANK_EFF != 0) state_next = ST_BLANK;
            default:  state_next = ST_BLANK;
        endcase
        // Without dead-time the whole slot is SHOW, including the first cycle after reset
        show_now  = (state_reg == ST_SHOW) || (BLANK_EFF == 0);
        handshake = upd_valid && !pend_valid_reg;
    end

    generate
        for (genvar gi = 0; gi < NUM_DIGITS; gi++) begin : g_anode
            assign anode_sel[gi] = ~(active_en_reg[gi] && (idx_reg == 3'(gi)));
        end
    endgenerate

    seg_hex_decode u_dec (
        .nibble (active_digits_reg[{idx_reg, 2'b00} +: 4]),
        .seg    (seg_dec)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_reg   <= '0;
            idx_reg   <= '0;
            state_reg <= ST_BLANK;
        end else begin
            cnt_reg   <= cnt_next;
            idx_reg   <= idx_next;
            state_reg <= state_next;
        end
    end

    // Pending buffer is promoted only on the last edge of a frame so a frame never tears
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pend_valid_reg    <= 1'b0;
            pend_digits_reg   <= '0;
            pend_en_reg       <= '0;
            pend_dp_reg       <= '0;
            active_digits_reg <= '0;
            active_en_reg     <= '0;
            active_dp_reg     <= '0;
        end else if (frame_end && pend_valid_reg) begin
            active_digits_reg <= pend_digits_reg;
            active_en_reg     <= pend_en_reg;
            active_dp_reg     <= pend_dp_reg;
            pend_valid_reg    <= 1'b0;
        end else if (handshake) begin
            pend_digits_reg   <= upd_digits;
            pend_en_reg       <= upd_en;
            pend_dp_reg       <= upd_dp;
            pend_valid_reg    <= 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            anode_reg       <= ANODE_OFF;
            seg_reg         <= SEG_OFF;
            dp_reg          <= 1'b1;
            frame_start_reg <= 1'b0;
        end else begin
            anode_reg       <= show_now ? anode_sel : ANODE_OFF;
            seg_reg         <= show_now ? seg_dec : SEG_OFF;
            dp_reg          <= show_now ? ~active_dp_reg[idx_reg] : 1'b1;
            frame_start_reg <= (idx_reg == 3'd0) && (cnt_reg == '0);
        end
    end

    assign anode       = anode_reg;
    assign seg         = seg_reg;
    assign dp          = dp_reg;
    assign frame_start = frame_start_reg;
    assign upd_ready   = ~pend_valid_reg;

endmodule
